// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup on fetch_pc; EX trains the table through a registered update port.
module branch_target_predictor #(
  parameter int ENTRIES   = 16,
  parameter int PC_WIDTH  = 32,
  parameter int MODE      = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_target,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic [1:0]           upd_kind,
  input  logic                 upd_taken,
  input  logic [PC_WIDTH-1:0]  upd_target,
  input  logic                 upd_mispredict,
  output logic [CNT_WIDTH-1:0] mispredict_count
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX - 2;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_RSVD   = 2'b11;

  // Update port: valid-only, no ready. Each cycle upd_valid=1 carries exactly one
  // resolved instruction that is consumed at that rising edge; there is no backpressure.

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]          kind_q   [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [IDX-1:0]   fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic             fetch_hit, upd_hit, upd_en;
  logic [1:0]       ctr_cur, ctr_next;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign fetch_idx = fetch_pc[IDX+1:2];
  assign fetch_tag = fetch_pc[PC_WIDTH-1:IDX+2];
  assign upd_idx   = upd_pc[IDX+1:2];
  assign upd_tag   = upd_pc[PC_WIDTH-1:IDX+2];

  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_en    = upd_valid && (upd_kind != KIND_RSVD) && !reset;

  // Prediction is masked during reset so stale valid bits never leak out.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if ((MODE != 0) && !reset && fetch_hit &&
        ((kind_q[fetch_idx] != KIND_BRANCH) || ctr_q[fetch_idx][1])) begin
      pred_taken  = 1'b1;
      pred_target = target_q[fetch_idx];
    end
  end

  always_comb begin
    ctr_cur  = ctr_q[upd_idx];
    ctr_next = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_en && !upd_hit && upd_taken) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload storage is not reset; valid_q alone decides whether an entry exists.
  always_ff @(posedge clock) begin
    if (upd_en) begin
      if (upd_hit) begin
        if (upd_kind == KIND_BRANCH) ctr_q[upd_idx] <= ctr_next;
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
          kind_q[upd_idx]   <= upd_kind;
        end
      end else if (upd_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        kind_q[upd_idx]   <= upd_kind;
        ctr_q[upd_idx]    <= (upd_kind == KIND_BRANCH) ? 2'b10 : 2'b11;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mispredict_count <= '0;
    end else if (upd_valid && upd_mispredict && (mispredict_count != {CNT_WIDTH{1'b1}})) begin
      mispredict_count <= mispredict_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a dynamic instance (4-bit mispredict
// counter) and a static not-taken instance share every input.
module tb_branch_target_predictor;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic        pred_taken, pred_taken_s;
  logic [31:0] pred_target, pred_target_s;
  logic [3:0]  mispredict_count;
  logic [31:0] mispredict_count_s;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  branch_target_predictor #(.ENTRIES(16), .PC_WIDTH(32), .MODE(1), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispredict_count(mispredict_count)
  );

  branch_target_predictor #(.ENTRIES(16), .PC_WIDTH(32), .MODE(0), .CNT_WIDTH(32)) dut_s (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken_s), .pred_target(pred_target_s),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispredict_count(mispredict_count_s)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // driver: one update presented for one edge
  task automatic do_update(input logic [31:0] pc, input logic [1:0] kind, input logic taken,
                           input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_kind = kind;
    upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
    @(posedge clock);
    #1 upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [31:0] exp_target);
    fetch_pc = pc;
    #1;
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
    check({tag, ".target"}, pred_target, exp_target);
    check({tag, ".static"}, {31'd0, pred_taken_s}, 32'd0);
  endtask

  initial begin
    fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_kind = 2'b00;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

    do_reset(2);
    for (int pc = 0; pc <= 252; pc += 4) look($sformatf("sweep_%0d", pc), pc, 1'b0, 32'd0);
    check("reset_count", {28'd0, mispredict_count}, 32'd0);

    // branch training on pc=8
    do_update(32'd8, 2'b00, 1'b1, 32'd16, 1'b0);
    look("br_alloc", 32'd8, 1'b1, 32'd16);
    do_update(32'd8, 2'b00, 1'b0, 32'd0, 1'b0);
    look("br_nt1", 32'd8, 1'b0, 32'd0);
    do_update(32'd8, 2'b00, 1'b0, 32'd0, 1'b0);
    look("br_nt2", 32'd8, 1'b0, 32'd0);
    do_update(32'd8, 2'b00, 1'b0, 32'd0, 1'b0);
    look("br_nt3_sat", 32'd8, 1'b0, 32'd0);
    do_update(32'd8, 2'b00, 1'b1, 32'd16, 1'b0);
    look("br_t1", 32'd8, 1'b0, 32'd0);
    do_update(32'd8, 2'b00, 1'b1, 32'd16, 1'b0);
    look("br_t2", 32'd8, 1'b1, 32'd16);
    // push to 11, saturate, then one not-taken keeps it taken (10)
    do_update(32'd8, 2'b00, 1'b1, 32'd16, 1'b0);
    do_update(32'd8, 2'b00, 1'b1, 32'd16, 1'b0);
    do_update(32'd8, 2'b00, 1'b0, 32'd0, 1'b0);
    look("br_sat_hi", 32'd8, 1'b1, 32'd16);
    do_update(32'd8, 2'b00, 1'b0, 32'd0, 1'b0);
    look("br_sat_hi_nt2", 32'd8, 1'b0, 32'd0);

    // jump allocation
    do_update(32'd48, 2'b10, 1'b1, 32'd64, 1'b0);
    look("jalr", 32'd48, 1'b1, 32'd64);
    do_update(32'd52, 2'b01, 1'b1, 32'd200, 1'b0);
    look("jal", 32'd52, 1'b1, 32'd200);

    // aliasing at index 2
    do_update(32'd72, 2'b00, 1'b1, 32'd100, 1'b0);
    look("alias_old", 32'd8, 1'b0, 32'd0);
    look("alias_new", 32'd72, 1'b1, 32'd100);
    do_update(32'd136, 2'b00, 1'b0, 32'd300, 1'b0);
    look("nt_miss_keep", 32'd72, 1'b1, 32'd100);
    look("nt_miss_none", 32'd136, 1'b0, 32'd0);
    do_update(32'd72, 2'b00, 1'b1, 32'd120, 1'b0);
    look("retarget", 32'd72, 1'b1, 32'd120);

    // reserved kind ignored
    do_update(32'd24, 2'b11, 1'b1, 32'd99, 1'b0);
    look("reserved", 32'd24, 1'b0, 32'd0);

    // same-cycle lookup/update: old contents this cycle
    fetch_pc = 32'd20;
    upd_valid = 1'b1; upd_pc = 32'd20; upd_kind = 2'b00;
    upd_taken = 1'b1; upd_target = 32'd40; upd_mispredict = 1'b0;
    #1 check("hazard_same", {31'd0, pred_taken}, 32'd0);
    @(posedge clock);
    #1 upd_valid = 1'b0;
    look("hazard_next", 32'd20, 1'b1, 32'd40);

    // mispredict counter: expected values come from the scoreboard queue
    do_update(32'd200, 2'b00, 1'b0, 32'd0, 1'b0);
    check("count_no_mis", {28'd0, mispredict_count}, 32'd0);
    upd_mispredict = 1'b1;
    @(posedge clock);
    #1 upd_mispredict = 1'b0;
    check("count_no_valid", {28'd0, mispredict_count}, 32'd0);
    for (int n = 1; n <= 20; n++) exp_q.push_back((n > 15) ? 32'd15 : n);
    for (int n = 1; n <= 20; n++) begin
      do_update(32'd200, 2'b00, 1'b0, 32'd0, 1'b1);
      check($sformatf("count_%0d", n), {28'd0, mispredict_count}, exp_q.pop_front());
    end
    check("count_static", mispredict_count_s, 32'd20);

    // reset mid-run with an update in the reset cycle
    reset = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'd12; upd_kind = 2'b01;
    upd_taken = 1'b1; upd_target = 32'd80; upd_mispredict = 1'b1;
    fetch_pc = 32'd72;
    #1 check("in_reset_pred", {31'd0, pred_taken}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    check("rst_count", {28'd0, mispredict_count}, 32'd0);
    check("rst_count_s", mispredict_count_s, 32'd0);
    look("rst_upd_dropped", 32'd12, 1'b0, 32'd0);
    look("rst_72", 32'd72, 1'b0, 32'd0);
    look("rst_48", 32'd48, 1'b0, 32'd0);
    look("rst_20", 32'd20, 1'b0, 32'd0);
    do_update(32'd12, 2'b01, 1'b1, 32'd80, 1'b0);
    look("post_rst_alloc", 32'd12, 1'b1, 32'd80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting beside the IF stage of the 5-stage RISCVCPU pipeline. It takes the fetch PC every cycle and, when enabled, supplies a predicted taken/target pair so IF can redirect without waiting for EX resolution. EX reports every resolved branch, jal or jalr back through an update port that trains the table. It also keeps a saturating mispredict counter for performance benches.

## Interface
- ENTRIES, 16: table depth; power of two, at least 2; IDX = log2(ENTRIES).
- PC_WIDTH, 32: PC and target width.
- MODE, 1: 0 = static not-taken, so pred_taken is always 0 and training still runs; 1 = dynamic prediction.
- CNT_WIDTH, 32: width of mispredict_count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- fetch_pc  in  PC_WIDTH  current IF PC.
- pred_taken  out  1  predict redirect for fetch_pc.
- pred_target  out  PC_WIDTH  predicted next PC; valid only when pred_taken=1, otherwise 0.
- upd_valid  in  1  one resolved control-transfer instruction this cycle.
- upd_pc  in  PC_WIDTH  PC of the resolved instruction.
- upd_kind  in  2  00 = conditional branch, 01 = jal, 10 = jalr, 11 = reserved and ignored.
- upd_taken  in  1  actual outcome; jal and jalr always drive 1.
- upd_target  in  PC_WIDTH  actual target.
- upd_mispredict  in  1  EX detected that the prediction was wrong.
- mispredict_count  out  CNT_WIDTH  saturating count of mispredicts.

## Operation
- Entry fields: valid, tag = pc[PC_WIDTH-1:IDX+2], target, kind, ctr[1:0].
- Index = pc[IDX+1:2]. pc[1:0] are ignored.
- Lookup is combinational on fetch_pc. A hit requires valid and a tag match.
- MODE=1 prediction:
  - pred_taken = hit & (kind != branch | ctr[1]).
  - pred_target = entry target.
- Update is registered at the clock edge when upd_valid=1 and upd_kind != 11.
  - Update hit (same index, valid, tag match):
    - Branch: ctr increments saturating at 11 when taken, decrements saturating at 00 when not taken.
    - Any kind: when taken, target and kind are overwritten with the new values.
  - Update miss:
    - If taken: allocate and overwrite the index unconditionally (direct-mapped replacement). ctr = 10 for a branch, 11 for jal or jalr.
    - If not taken: no allocation, table unchanged.
- mispredict_count increments by 1 when upd_valid & upd_mispredict. It holds at all-ones and never wraps.
- Flushes are handled by the pipeline; the table is not affected by them.

## Timing
- Lookup has zero latency: pred_taken and pred_target depend on fetch_pc and current state only.
- An update written at edge N is visible to lookups from the cycle after edge N.
- Same-cycle lookup and update to the same index: the lookup sees the old contents. No bypass.
- Reset (synchronous, any cycle, including mid-training):
  - all valid bits clear to 0 and mispredict_count goes to 0;
  - target, tag and ctr storage need not be reset;
  - during and after reset, pred_taken = 0 and pred_target = 0 until a new allocation;
  - an update presented in the reset cycle is discarded.
- Aliasing: two PCs with equal index but different tag evict each other. A stale tag is never a hit.
- Counter saturation: 11 + taken stays 11; 00 + not-taken stays 00.
- A 00 counter in a valid entry keeps the entry valid; it predicts not-taken.

## Test plan
- Reset then lookup: hold reset 2 cycles, sweep fetch_pc 0..252 -> pred_taken=0 and pred_target=0 everywhere, mispredict_count=0.
- Branch training:
  - Update pc=8, kind=00, taken=1, target=16 -> next cycle fetch_pc=8 gives pred_taken=1, pred_target=16.
  - Two not-taken updates -> pred_taken=0 (ctr 10->01->00).
  - A third not-taken update leaves ctr=00.
  - One taken update -> still 0 (ctr=01).
  - Another taken update -> 1.
- Jump allocation: update pc=48, kind=10 (jalr), target=64 -> fetch_pc=48 gives pred_taken=1, target 64. With MODE=0, same sequence -> pred_taken=0.
- Aliasing with ENTRIES=16:
  - Allocate pc=8 (target 16).
  - Allocate pc=72 (same index 2, target 100) -> fetch_pc=8 misses, fetch_pc=72 predicts 100.
  - Not-taken miss update on pc=136 -> no change.
- Same-cycle hazard: update pc=20 taken to target 40 while fetch_pc=20 in the same cycle -> pred_taken=0 that cycle, 1 on the next.
- Counter saturation and reset mid-run:
  - Force mispredict_count near all-ones (CNT_WIDTH=4), issue 20 mispredicts -> holds at 15.
  - Assert reset for one cycle with upd_valid=1 -> count=0, all lookups miss, the update is not applied.
